vga_capture: RTL

//  Receive-side VGA monitor: samples hsync/vsync/rgb as produced by the display path (640x480,

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_sync_edge.sv | 29 ++
 rtl/vga_capture.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: timing constants for the 640x480 display path (shared with vga_sync),
// the capture FSM state encoding and the pixel coordinate type.
// No ports. The vga_capture parameter defaults are taken from these constants.
package vga_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int   VGA_H_DISPLAY    = 640;
    localparam int   VGA_H_SYNC_START = 656;
    localparam int   VGA_H_TOTAL      = 800;
    localparam int   VGA_V_DISPLAY    = 480;
    localparam int   VGA_V_SYNC_START = 490;
    localparam int   VGA_V_TOTAL      = 525;
    localparam logic VGA_SYNC_ACTIVE  = 1'b1;
    localparam int   VGA_RGB_DELAY    = 1;
    localparam int   VGA_LOCK_FRAMES  = 2;
    localparam int   VGA_CLK_PER_PIX  = 2;

    // Capture FSM encoding.
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Counter advance with wrap at 'last'.
    function automatic coord_t wrap_inc(input coord_t cnt, input coord_t last);
        coord_t result;
        if (cnt == last) begin
            result = coord_t'(0);
        end else begin
            result = cnt + coord_t'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers one sync input and flags its leading edge.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_sig          : raw sync input (synchronous to i_clk)
//   o_edge         : high on the clk where i_sig is active but was inactive the clk before
module vga_sync_edge #(
    parameter logic ACTIVE = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_edge
);

    logic r_q;

    // One-clk history of the sync input; reset to the inactive level so a sync
    // already asserted when reset is released still yields an edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_q <= ~ACTIVE;
        end else begin
            r_q <= i_sig;
        end
    end

    assign o_edge = (i_sig == ACTIVE) && (r_q != ACTIVE);

endmodule

// File: rtl/vga_capture.sv
// vga_capture: receive-side VGA monitor on a loopback of the display outputs.
// Recovers pixel coordinates from hsync/vsync, strobes every visible pixel while
// locked, and flags sync edges that arrive at an unexpected count.
// Ports:
//   i_clk, i_reset          : clock, asynchronous active-high reset
//   i_hsync, i_vsync, i_rgb : display signals, synchronous to i_clk
//   o_pix_x, o_pix_y        : coordinate of the sampled pixel (held between strobes)
//   o_pix_rgb               : sampled colour
//   o_pix_valid             : 1-clk strobe per visible pixel while locked
//   o_frame_start           : 1-clk pulse with the strobe of pixel (0,0)
//   o_locked                : timing locked
//   o_sync_err              : 1-clk pulse on a sync edge at an unexpected count
module vga_capture
    import vga_pkg::*;
#(
    parameter int   H_DISPLAY    = VGA_H_DISPLAY,
    parameter int   H_SYNC_START = VGA_H_SYNC_START,
    parameter int   H_TOTAL      = VGA_H_TOTAL,
    parameter int   V_DISPLAY    = VGA_V_DISPLAY,
    parameter int   V_SYNC_START = VGA_V_SYNC_START,
    parameter int   V_TOTAL      = VGA_V_TOTAL,
    parameter logic SYNC_ACTIVE  = VGA_SYNC_ACTIVE,
    parameter int   RGB_DELAY    = VGA_RGB_DELAY,
    parameter int   LOCK_FRAMES  = VGA_LOCK_FRAMES,
    parameter int   CLK_PER_PIX  = VGA_CLK_PER_PIX
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_hsync,
    input  logic               i_vsync,
    input  logic [2:0]         i_rgb,
    output logic [COORD_W-1:0] o_pix_x,
    output logic [COORD_W-1:0] o_pix_y,
    output logic [2:0]         o_pix_rgb,
    output logic               o_pix_valid,
    output logic               o_frame_start,
    output logic               o_locked,
    output logic               o_sync_err
);

    localparam int PH_W   = (CLK_PER_PIX > 2) ? $clog2(CLK_PER_PIX) : 1;
    localparam int GOOD_W = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;

    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLK_PER_PIX - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);
    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_SS     = coord_t'(H_SYNC_START);
    localparam coord_t V_SS     = coord_t'(V_SYNC_START);
    localparam coord_t RGB_D    = coord_t'(RGB_DELAY);
    localparam coord_t H_VIS_HI = coord_t'(H_DISPLAY + RGB_DELAY);
    localparam coord_t V_VIS_HI = coord_t'(V_DISPLAY);

    // State registers
    logic [PH_W-1:0]   r_phase;
    coord_t            r_h;
    coord_t            r_v;
    logic [1:0]        r_state;
    logic [GOOD_W-1:0] r_good;

    // Output registers
    coord_t            r_pix_x;
    coord_t            r_pix_y;
    logic [2:0]        r_pix_rgb;
    logic              r_pix_valid;
    logic              r_frame_start;
    logic              r_locked;
    logic              r_sync_err;

    // Combinational
    logic              w_hs_edge;
    logic              w_vs_edge;
    logic [PH_W-1:0]   w_phase_cur;
    logic [PH_W-1:0]   w_phase_next;
    logic              w_tick;
    coord_t            w_h_pred;
    coord_t            w_v_pred;
    coord_t            w_v_exp;
    coord_t            w_h_new;
    coord_t            w_v_new;
    logic              w_hs_bad;
    logic              w_vs_bad;
    logic              w_err;
    logic [1:0]        w_state_next;
    logic [GOOD_W-1:0] w_good_next;
    coord_t            w_pix_x;
    logic              w_sample;

    vga_sync_edge #(.ACTIVE(SYNC_ACTIVE)) u_hs_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_sig   (i_hsync),
        .o_edge  (w_hs_edge)
    );

    vga_sync_edge #(.ACTIVE(SYNC_ACTIVE)) u_vs_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_sig   (i_vsync),
        .o_edge  (w_vs_edge)
    );

    // Pixel tick: an hsync leading edge realigns the phase so that the edge clk is a tick.
    always_comb begin
        w_phase_cur = w_hs_edge ? {PH_W{1'b0}} : r_phase;
        w_tick      = (w_phase_cur == {PH_W{1'b0}});
        if (w_phase_cur == PH_LAST) begin
            w_phase_next = {PH_W{1'b0}};
        end else begin
            w_phase_next = w_phase_cur + PH_W'(1);
        end
    end

    // Counter prediction, sync-edge checks and counter reload.
    // After a tick, r_h/r_v name the pixel whose signals are on the inputs at that clk,
    // so an edge is expected exactly when the predicted count equals the sync start.
    always_comb begin
        w_h_pred = wrap_inc(r_h, H_LAST);
        if (r_h == H_LAST) begin
            w_v_pred = wrap_inc(r_v, V_LAST);
        end else begin
            w_v_pred = r_v;
        end
        w_v_exp  = w_tick ? w_v_pred : r_v;
        w_hs_bad = w_hs_edge && (w_h_pred != H_SS);
        w_vs_bad = w_vs_edge && (w_v_exp != V_SS);
        w_err    = (r_state != ST_SEARCH) && (w_hs_bad || w_vs_bad);
        if (w_hs_edge) begin
            w_h_new = H_SS;
        end else if (w_tick) begin
            w_h_new = w_h_pred;
        end else begin
            w_h_new = r_h;
        end
        if (w_vs_edge) begin
            w_v_new = V_SS;
        end else begin
            w_v_new = w_v_exp;
        end
    end

    // Lock FSM: count consecutive good vsync edges; any bad edge restarts tracking.
    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good;
        case (r_state)
            ST_SEARCH: begin
                if (w_vs_edge) begin
                    w_state_next = ST_TRACK;
                    w_good_next  = {GOOD_W{1'b0}};
                end else begin
                    w_state_next = ST_SEARCH;
                end
            end
            ST_TRACK: begin
                if (w_err) begin
                    w_good_next = {GOOD_W{1'b0}};
                end else if (w_vs_edge) begin
                    if (r_good == GOOD_LAST) begin
                        w_state_next = ST_LOCKED;
                        w_good_next  = {GOOD_W{1'b0}};
                    end else begin
                        w_good_next = r_good + GOOD_W'(1);
                    end
                end else begin
                    w_state_next = ST_TRACK;
                end
            end
            ST_LOCKED: begin
                if (w_err) begin
                    w_state_next = ST_TRACK;
                    w_good_next  = {GOOD_W{1'b0}};
                end else begin
                    w_state_next = ST_LOCKED;
                end
            end
            default: begin
                w_state_next = ST_SEARCH;
                w_good_next  = {GOOD_W{1'b0}};
            end
        endcase
    end

    // Visible-pixel select: rgb lags its coordinate by RGB_DELAY ticks, and a pixel
    // coinciding with a bad sync edge is dropped.
    always_comb begin
        w_pix_x  = w_h_new - RGB_D;
        w_sample = w_tick && (r_state == ST_LOCKED) && !w_err &&
                   (w_h_new >= RGB_D) && (w_h_new < H_VIS_HI) && (w_v_new < V_VIS_HI);
    end

    // Tick phase, coordinate counters and FSM state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_phase <= {PH_W{1'b0}};
            r_h     <= coord_t'(0);
            r_v     <= coord_t'(0);
            r_state <= ST_SEARCH;
            r_good  <= {GOOD_W{1'b0}};
        end else begin
            r_phase <= w_phase_next;
            r_h     <= w_h_new;
            r_v     <= w_v_new;
            r_state <= w_state_next;
            r_good  <= w_good_next;
        end
    end

    // Registered outputs; pixel fields only update on a strobe.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pix_x       <= coord_t'(0);
            r_pix_y       <= coord_t'(0);
            r_pix_rgb     <= 3'd0;
            r_pix_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            if (w_sample) begin
                r_pix_x   <= w_pix_x;
                r_pix_y   <= w_v_new;
                r_pix_rgb <= i_rgb;
            end
            r_pix_valid   <= w_sample;
            r_frame_start <= w_sample && (w_pix_x == coord_t'(0)) && (w_v_new == coord_t'(0));
            r_locked      <= (w_state_next == ST_LOCKED);
            r_sync_err    <= w_err;
        end
    end

    assign o_pix_x       = r_pix_x;
    assign o_pix_y       = r_pix_y;
    assign o_pix_rgb     = r_pix_rgb;
    assign o_pix_valid   = r_pix_valid;
    assign o_frame_start = r_frame_start;
    assign o_locked      = r_locked;
    assign o_sync_err    = r_sync_err;

endmodule
